// File: rtl/goofy_pkg.sv
// Shared types and constants for the goofy instruction fetch stage.
package goofy_pkg;
  localparam int INST_BYTES = 3;
  localparam int BYTE_W     = 8;
  localparam int PC_W       = 16;

  typedef enum logic [1:0] {B_IOP = 2'd0, B_OP0 = 2'd1, B_OP1 = 2'd2} byte_idx_t;

  typedef struct packed {
    logic [BYTE_W-1:0] iop;
    logic [BYTE_W-1:0] op0;
    logic [BYTE_W-1:0] op1;
    logic [PC_W-1:0]   pc;
  } inst_t;

  function automatic byte_idx_t next_idx(input byte_idx_t b);
    return (int'(b) == INST_BYTES - 1) ? B_IOP : byte_idx_t'(b + 2'd1);
  endfunction
endpackage

// File: rtl/goofy_inst_fifo.sv
// Small synchronous instruction queue; flush wins over push and pop.
module goofy_inst_fifo
  import goofy_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  inst_t         wdata,
  output inst_t         head,
  output logic [CW-1:0] count
);
  inst_t         mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the head outputs read zero afterwards.
  always_ff @(posedge clk) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk)
    if (res && !flush && push && !pop) assert (count != CW'(DEPTH));
endmodule

// File: rtl/goofy_fetch.sv
// Instruction fetch: issues byte reads, assembles 3-byte instructions and
// queues them for the core; supports redirect flush and halt.
module goofy_fetch
  import goofy_pkg::*;
#(
  parameter int                ADDR_W       = PC_W,
  parameter int                DEPTH        = 2,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              res,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_gnt,
  input  logic [7:0]        ram_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [7:0]        inst_iop,
  output logic [7:0]        inst_op0,
  output logic [7:0]        inst_op1,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc, asm_pc;
  byte_idx_t         byte_idx, issue_idx;
  logic              rd_pending, squash;
  logic [7:0]        b_iop, b_op0;
  logic [CW-1:0]     count;
  logic              in_asm, room, capture, push;
  inst_t             head, wdata;

  // Slot reservation happens when an instruction's first byte issues; the
  // remaining bytes of an already-reserved instruction never need new room.
  assign in_asm   = rd_pending || (byte_idx != B_IOP);
  assign room     = (issue_idx != B_IOP) || ((int'(count) + int'(in_asm)) < DEPTH);
  assign ram_rd   = ram_gnt && !halt && !redirect && room;
  assign ram_addr = fetch_pc;

  assign capture = rd_pending && !squash && !redirect;
  assign push    = capture && (byte_idx == B_OP1);
  assign wdata   = '{iop: b_iop, op0: b_op0, op1: ram_rdata, pc: PC_W'(asm_pc)};

  goofy_inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (push),
    .pop   (inst_valid && inst_ready && !redirect),
    .flush (redirect),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  assign inst_valid = (count != '0);
  assign inst_iop   = head.iop;
  assign inst_op0   = head.op0;
  assign inst_op1   = head.op1;
  assign inst_pc    = ADDR_W'(head.pc);

  always_ff @(posedge clk) begin
    if (!res) begin
      fetch_pc   <= RESET_VECTOR;
      byte_idx   <= B_IOP;
      issue_idx  <= B_IOP;
      rd_pending <= 1'b0;
      squash     <= 1'b0;
      b_iop      <= '0;
      b_op0      <= '0;
      asm_pc     <= '0;
    end else if (redirect) begin
      fetch_pc   <= redirect_pc;
      byte_idx   <= B_IOP;
      issue_idx  <= B_IOP;
      rd_pending <= 1'b0;
      // Any response still on the bus belongs to the old stream.
      squash     <= rd_pending;
    end else begin
      squash     <= 1'b0;
      rd_pending <= ram_rd;
      if (ram_rd) begin
        fetch_pc  <= fetch_pc + 1'b1;
        issue_idx <= next_idx(issue_idx);
      end
      if (capture) begin
        byte_idx <= next_idx(byte_idx);
        case (byte_idx)
          B_IOP: begin
            b_iop  <= ram_rdata;
            // fetch_pc has advanced exactly once since this byte issued.
            asm_pc <= fetch_pc - 1'b1;
          end
          B_OP0:   b_op0 <= ram_rdata;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_goofy_fetch.sv
// Self-checking bench for goofy_fetch: directed scenarios plus randomized
// grant/ready/halt streams checked against a RAM-content reference.
module tb_goofy_fetch;
  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        ram_rd;
  logic [15:0] ram_addr;
  logic        ram_gnt = 1'b0;
  logic [7:0]  ram_rdata = 8'h00;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [7:0]  inst_iop, inst_op0, inst_op1;
  logic [15:0] inst_pc;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram [0:65535];
  logic [15:0] addr_q [$];
  logic [39:0] got_q [$];

  goofy_fetch dut (
    .clk(clk), .res(res), .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_gnt(ram_gnt),
    .ram_rdata(ram_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_iop(inst_iop), .inst_op0(inst_op0), .inst_op1(inst_op1), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
  );

  always #5 clk = ~clk;

  // RAM: data for a request appears the cycle after; otherwise noise.
  always @(posedge clk) ram_rdata <= ram_rd ? ram[ram_addr] : 8'($urandom);

  // Monitor: records issued addresses and transferred instructions.
  always @(negedge clk) begin
    #4;
    if (res) begin
      assert (!(redirect && inst_valid && inst_ready));
      if (ram_rd) addr_q.push_back(ram_addr);
      if (inst_valid && inst_ready && !redirect)
        got_q.push_back({inst_iop, inst_op0, inst_op1, inst_pc});
    end
  end

  function automatic logic [39:0] exp_inst(input logic [15:0] pc);
    logic [15:0] a1, a2;
    a1 = pc + 16'd1;
    a2 = pc + 16'd2;
    return {ram[pc], ram[a1], ram[a2], pc};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    res = 1'b0; ram_gnt = 1'b0; inst_ready = 1'b0; halt = 1'b0; redirect = 1'b0;
    repeat (2) @(posedge clk);
    addr_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); #1;
    checks++; if (ram_rd !== 1'b0) begin errors++; $display("FAIL reset_ram_rd got %b exp 0", ram_rd); end
    checks++; if (ram_addr !== 16'h0000) begin errors++; $display("FAIL reset_ram_addr got %h exp 0000", ram_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
    checks++;
    if ({inst_iop, inst_op0, inst_op1, inst_pc} !== 40'h0) begin
      errors++; $display("FAIL reset_head got %h exp 0", {inst_iop, inst_op0, inst_op1, inst_pc});
    end
  endtask

  task automatic test_latency();
    logic [15:0] c16;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      res = 1'b1; ram_gnt = 1'b1; inst_ready = 1'b1;
      #1;
      c16 = 16'(c);
      checks++;
      if (!(ram_rd === 1'b1 && ram_addr === c16)) begin
        errors++; $display("FAIL lat_issue c%0d got rd=%b addr=%h exp rd=1 addr=%h", c, ram_rd, ram_addr, c16);
      end
      checks++;
      if (inst_valid !== (c == 4 || c == 7)) begin
        errors++; $display("FAIL lat_valid c%0d got %b exp %b", c, inst_valid, (c == 4 || c == 7));
      end
      if (c == 4) begin
        checks++;
        if ({inst_iop, inst_op0, inst_op1, inst_pc} !== 40'h01_10_20_0000) begin
          errors++; $display("FAIL lat_first got %h exp 0110200000", {inst_iop, inst_op0, inst_op1, inst_pc});
        end
      end
      if (c == 7) begin
        checks++;
        if ({inst_iop, inst_op0, inst_op1, inst_pc} !== 40'h02_30_40_0003) begin
          errors++; $display("FAIL lat_second got %h exp 0230400003", {inst_iop, inst_op0, inst_op1, inst_pc});
        end
      end
    end
  endtask

  task automatic test_full();
    int late;
    late = 0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      res = 1'b1; ram_gnt = 1'b1; inst_ready = 1'b0;
      #1;
      if (c >= 6 && ram_rd) late++;
    end
    checks++; if (late !== 0) begin errors++; $display("FAIL full_late_reads got %0d exp 0", late); end
    checks++; if (addr_q.size() !== 6) begin errors++; $display("FAIL full_issue_count got %0d exp 6", addr_q.size()); end
    for (int i = 0; i < addr_q.size() && i < 6; i++) begin
      checks++;
      if (addr_q[i] !== 16'(i)) begin errors++; $display("FAIL full_addr[%0d] got %h exp %h", i, addr_q[i], 16'(i)); end
    end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %b exp 1", inst_valid); end
    @(negedge clk); inst_ready = 1'b1; #1;
    checks++;
    if ({inst_iop, inst_op0, inst_op1, inst_pc} !== exp_inst(16'h0000)) begin
      errors++; $display("FAIL full_pop0 got %h exp %h", {inst_iop, inst_op0, inst_op1, inst_pc}, exp_inst(16'h0000));
    end
    @(negedge clk); #1;
    checks++;
    if (!(inst_valid === 1'b1 && {inst_iop, inst_op0, inst_op1, inst_pc} === exp_inst(16'h0003))) begin
      errors++; $display("FAIL full_pop1 got v=%b %h exp v=1 %h", inst_valid, {inst_iop, inst_op0, inst_op1, inst_pc}, exp_inst(16'h0003));
    end
  endtask

  task automatic test_grant_toggle();
    logic gpat [0:4];
    gpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      res = 1'b1; inst_ready = 1'b1;
      ram_gnt = (c < 5) ? gpat[c] : 1'b0;
    end
    checks++;
    if (addr_q.size() !== 3 || addr_q[0] !== 16'h0 || addr_q[1] !== 16'h1 || addr_q[2] !== 16'h2) begin
      errors++; $display("FAIL gnt_addr_seq got n=%0d exp n=3 seq 0,1,2", addr_q.size());
    end
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== exp_inst(16'h0000)) begin
      errors++; $display("FAIL gnt_inst got n=%0d %h exp n=1 %h", got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : 40'h0, exp_inst(16'h0000));
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      res = 1'b1; ram_gnt = 1'b1; inst_ready = 1'b0;
    end
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 16'h0040; #1;
    checks++; if (ram_rd !== 1'b0) begin errors++; $display("FAIL redir_rd got %b exp 0", ram_rd); end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL redir_q1 got %b exp 1", inst_valid); end
    addr_q.delete();
    @(negedge clk);
    redirect = 1'b0; #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b exp 0", inst_valid); end
    checks++;
    if (!(ram_rd === 1'b1 && ram_addr === 16'h0040)) begin
      errors++; $display("FAIL redir_first_addr got rd=%b %h exp rd=1 0040", ram_rd, ram_addr);
    end
    inst_ready = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (got_q.size() < 1 || got_q[0] !== exp_inst(16'h0040)) begin
      errors++; $display("FAIL redir_inst got n=%0d %h exp %h", got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : 40'h0, exp_inst(16'h0040));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    ram[16'hFFFE] = 8'h05; ram[16'hFFFF] = 8'h06; ram[16'h0000] = 8'h07;
    @(negedge clk);
    res = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFE; ram_gnt = 1'b1; inst_ready = 1'b0;
    @(negedge clk);
    redirect = 1'b0; inst_ready = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (got_q.size() < 1 || got_q[0] !== 40'h05_06_07_FFFE) begin
      errors++; $display("FAIL wrap_inst got %h exp 050607fffe", (got_q.size() > 0) ? got_q[0] : 40'h0);
    end
    checks++;
    if (addr_q.size() < 4 || addr_q[2] !== 16'h0000 || addr_q[3] !== 16'h0001) begin
      errors++; $display("FAIL wrap_addr got n=%0d exp ...,0000,0001", addr_q.size());
    end
  endtask

  task automatic test_halt_reset();
    do_reset();
    @(negedge clk);
    res = 1'b1; ram_gnt = 1'b1; inst_ready = 1'b1; #1;
    checks++; if (!(ram_rd === 1'b1 && ram_addr === 16'h0)) begin errors++; $display("FAIL halt_first got rd=%b %h exp rd=1 0000", ram_rd, ram_addr); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); halt = 1'b1; #1;
      checks++; if (ram_rd !== 1'b0) begin errors++; $display("FAIL halt_rd c%0d got %b exp 0", c, ram_rd); end
    end
    @(negedge clk); halt = 1'b0; #1;
    checks++; if (!(ram_rd === 1'b1 && ram_addr === 16'h1)) begin errors++; $display("FAIL halt_resume got rd=%b %h exp rd=1 0001", ram_rd, ram_addr); end
    repeat (5) @(negedge clk);
    checks++;
    if (got_q.size() < 1 || got_q[0] !== exp_inst(16'h0000)) begin
      errors++; $display("FAIL halt_inst got %h exp %h", (got_q.size() > 0) ? got_q[0] : 40'h0, exp_inst(16'h0000));
    end
    halt = 1'b1; res = 1'b0;
    @(negedge clk);
    res = 1'b1; halt = 1'b0; ram_gnt = 1'b0; #1;
    checks++;
    if ({ram_rd, ram_addr, inst_valid, inst_iop, inst_op0, inst_op1, inst_pc} !== 58'h0) begin
      errors++; $display("FAIL halt_reset_outs got rd=%b a=%h v=%b %h exp all zero", ram_rd, ram_addr, inst_valid,
                         {inst_iop, inst_op0, inst_op1, inst_pc});
    end
    @(negedge clk); ram_gnt = 1'b1; #1;
    checks++; if (!(ram_rd === 1'b1 && ram_addr === 16'h0)) begin errors++; $display("FAIL halt_restart got rd=%b %h exp rd=1 0000", ram_rd, ram_addr); end
  endtask

  task automatic test_random_stream();
    logic [15:0] start, e;
    int bad;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      start = 16'($urandom);
      @(negedge clk);
      res = 1'b1; redirect = 1'b1; redirect_pc = start; ram_gnt = 1'b0; inst_ready = 1'b0;
      for (int c = 0; c < 150; c++) begin
        @(negedge clk);
        redirect   = 1'b0;
        ram_gnt    = ($urandom_range(0, 3) != 0);
        inst_ready = 1'($urandom_range(0, 1));
        halt       = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      ram_gnt = 1'b0; halt = 1'b0; inst_ready = 1'b1;
      repeat (12) @(negedge clk);
      bad = 0;
      for (int i = 0; i < addr_q.size(); i++) begin
        e = start + 16'(i);
        if (addr_q[i] !== e) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rnd%0d_addr_seq got %0d bad exp 0", r, bad); end
      checks++;
      if (got_q.size() !== addr_q.size() / 3) begin
        errors++; $display("FAIL rnd%0d_count got %0d exp %0d", r, got_q.size(), addr_q.size() / 3);
      end
      bad = 0;
      for (int i = 0; i < got_q.size(); i++) begin
        e = start + 16'(3 * i);
        if (got_q[i] !== exp_inst(e)) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rnd%0d_insts got %0d bad exp 0", r, bad); end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h01; ram[1] = 8'h10; ram[2] = 8'h20;
    ram[3] = 8'h02; ram[4] = 8'h30; ram[5] = 8'h40;
    test_reset();
    test_latency();
    test_full();
    test_grant_toggle();
    test_redirect();
    test_halt_reset();
    test_random_stream();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
